pipelined_core_fwd: RTL and testbench

- Single-clock, 5-stage (IF/ID/EX/MEM/WB) in-order integer core; successor to the two-phase pipelined processor.
- Keeps the same 32-bit instruction format and opcodes; adds parametrised data/address width, full forwarding, load-use interlock and conditional branches with flush.
- Memories are external, so benches and SoC wrappers supply instruction and data storage.

---
 rtl/core_pkg.sv | 67 ++++++
 rtl/core_fwd_unit.sv | 49 ++++
 rtl/pipelined_core_fwd.sv | 231 +++++++++++++++++++++++
 tb/tb_pipelined_core_fwd.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared opcodes, instruction classes and field positions for the 5-stage core.
package core_pkg;

   localparam int unsigned ILEN    = 32;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned RIDX_W  = 5;
   localparam int unsigned OP_MSB  = 31;
   localparam int unsigned OP_LSB  = 26;
   localparam int unsigned RS_MSB  = 25;
   localparam int unsigned RS_LSB  = 21;
   localparam int unsigned RT_MSB  = 20;
   localparam int unsigned RT_LSB  = 16;
   localparam int unsigned RD_MSB  = 15;
   localparam int unsigned RD_LSB  = 11;
   localparam int unsigned IMM_MSB = 15;

   typedef logic [OP_W-1:0] opcode_t;

   localparam opcode_t OP_ADD  = 6'b000000;
   localparam opcode_t OP_SUB  = 6'b000001;
   localparam opcode_t OP_AND  = 6'b000010;
   localparam opcode_t OP_OR   = 6'b000011;
   localparam opcode_t OP_CMP  = 6'b000100;
   localparam opcode_t OP_MUL  = 6'b000101;
   localparam opcode_t OP_LW   = 6'b001000;
   localparam opcode_t OP_SW   = 6'b001001;
   localparam opcode_t OP_ADDI = 6'b001010;
   localparam opcode_t OP_SUBI = 6'b001011;
   localparam opcode_t OP_CMPI = 6'b001100;
   localparam opcode_t OP_BEQZ = 6'b001101;
   localparam opcode_t OP_BNEZ = 6'b001110;
   localparam opcode_t OP_HLT  = 6'b111111;

   typedef enum logic [2:0] {
      NONE, RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT
   } itype_e;

   typedef enum logic [1:0] {
      FWD_REG, FWD_EXMEM, FWD_MEMWB
   } fwd_sel_e;

   // Unknown opcodes are treated as HLT so a stray word stops the core.
   function automatic itype_e decode_type(input opcode_t op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_CMP, OP_MUL: return RR_ALU;
         OP_ADDI, OP_SUBI, OP_CMPI:                      return RM_ALU;
         OP_LW:                                          return LOAD;
         OP_SW:                                          return STORE;
         OP_BEQZ, OP_BNEZ:                               return BRANCH;
         OP_HLT:                                         return HALT;
         default:                                        return HALT;
      endcase
   endfunction

   function automatic logic writes_reg(input itype_e t);
      return (t == RR_ALU) || (t == RM_ALU) || (t == LOAD);
   endfunction

   function automatic logic uses_rs(input itype_e t);
      return (t == RR_ALU) || (t == RM_ALU) || (t == LOAD) || (t == STORE) || (t == BRANCH);
   endfunction

   function automatic logic uses_rt(input itype_e t);
      return (t == RR_ALU) || (t == STORE);
   endfunction

endpackage

// File: rtl/core_fwd_unit.sv
// Operand forwarding select for EX and load-use hazard detection for ID.
module core_fwd_unit
   import core_pkg::*;
(
   input  itype_e              id_type_i,
   input  logic [RIDX_W-1:0]   id_rs_i,
   input  logic [RIDX_W-1:0]   id_rt_i,
   input  itype_e              ex_type_i,
   input  logic [RIDX_W-1:0]   ex_rs_i,
   input  logic [RIDX_W-1:0]   ex_rt_i,
   input  logic [RIDX_W-1:0]   ex_dst_i,
   input  itype_e              exmem_type_i,
   input  logic [RIDX_W-1:0]   exmem_dst_i,
   input  itype_e              memwb_type_i,
   input  logic [RIDX_W-1:0]   memwb_dst_i,
   output fwd_sel_e            fwd_a_c_o,
   output fwd_sel_e            fwd_b_c_o,
   output logic                load_use_c_o
);

   logic exmem_fwd_ok;
   logic memwb_fwd_ok;

   // Youngest producer wins; a load in EX/MEM has no value yet and is never a source.
   always_comb begin
      fwd_a_c_o    = FWD_REG;
      fwd_b_c_o    = FWD_REG;
      exmem_fwd_ok = writes_reg(exmem_type_i) && (exmem_type_i != LOAD) && (exmem_dst_i != '0);
      memwb_fwd_ok = writes_reg(memwb_type_i) && (memwb_dst_i != '0);
      if (exmem_fwd_ok && (exmem_dst_i == ex_rs_i)) begin
         fwd_a_c_o = FWD_EXMEM;
      end else if (memwb_fwd_ok && (memwb_dst_i == ex_rs_i)) begin
         fwd_a_c_o = FWD_MEMWB;
      end
      if (exmem_fwd_ok && (exmem_dst_i == ex_rt_i)) begin
         fwd_b_c_o = FWD_EXMEM;
      end else if (memwb_fwd_ok && (memwb_dst_i == ex_rt_i)) begin
         fwd_b_c_o = FWD_MEMWB;
      end
   end

   // A load in EX whose target is read by the instruction in ID needs one bubble.
   always_comb begin
      load_use_c_o = (ex_type_i == LOAD) &&
                     ((uses_rs(id_type_i) && (ex_dst_i == id_rs_i)) ||
                      (uses_rt(id_type_i) && (ex_dst_i == id_rt_i)));
   end

endmodule

// File: rtl/pipelined_core_fwd.sv
// 5-stage in-order integer core with full forwarding, load-use interlock and branch flush.
module pipelined_core_fwd
   import core_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 10,
   parameter int unsigned NREG = 32
)(
   input  logic              clk,
   input  logic              rst,
   output logic [AW-1:0]     imem_addr,
   input  logic [ILEN-1:0]   imem_rdata,
   output logic [AW-1:0]     dmem_addr,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic [XLEN-1:0]   dmem_wdata,
   output logic              dmem_we,
   output logic              retire,
   output logic              halted,
   input  logic [RIDX_W-1:0] dbg_raddr,
   output logic [XLEN-1:0]   dbg_rdata
);

   localparam int unsigned RF_AW = (NREG > 1) ? $clog2(NREG) : 1;

   logic [AW-1:0]     pc_q, pc_d;
   logic              stop_q, stop_d, halted_q;
   logic              ifid_vld_q, ifid_vld_d, ifid_ld_c;
   logic [ILEN-1:0]   ifid_ir_q;
   logic [AW-1:0]     ifid_npc_q;
   itype_e            idex_type_q, exmem_type_q, memwb_type_q;
   opcode_t           idex_op_q;
   logic [RIDX_W-1:0] idex_rs_q, idex_rt_q, idex_dst_q, exmem_dst_q, memwb_dst_q;
   logic [XLEN-1:0]   idex_a_q, idex_b_q, idex_imm_q;
   logic [AW-1:0]     idex_npc_q;
   logic [XLEN-1:0]   exmem_alu_q, exmem_sd_q, memwb_res_q;
   logic [XLEN-1:0]   rf_q [NREG];

   itype_e            id_type_c;
   opcode_t           id_op_c;
   logic [RIDX_W-1:0] id_rs_c, id_rt_c, id_dst_c;
   logic [XLEN-1:0]   id_a_c, id_b_c, id_imm_c;
   logic              wb_we_c, stall_c, load_use_c, hlt_in_id_c, br_taken_c;
   logic [AW-1:0]     br_tgt_c;
   fwd_sel_e          fwd_a_c, fwd_b_c;
   logic [XLEN-1:0]   ex_a_c, ex_rt_c, ex_b_c, ex_alu_c;

   function automatic logic in_rf(input logic [RIDX_W-1:0] idx);
      return (idx != '0) && (32'(idx) < NREG);
   endfunction

   // ID decode and register read with same-cycle WB bypass.
   always_comb begin
      id_op_c   = ifid_ir_q[OP_MSB:OP_LSB];
      id_type_c = ifid_vld_q ? decode_type(id_op_c) : NONE;
      id_rs_c   = ifid_ir_q[RS_MSB:RS_LSB];
      id_rt_c   = ifid_ir_q[RT_MSB:RT_LSB];
      id_imm_c  = XLEN'($signed(ifid_ir_q[IMM_MSB:0]));
      id_dst_c  = '0;
      if (id_type_c == RR_ALU) begin
         id_dst_c = ifid_ir_q[RD_MSB:RD_LSB];
      end else if ((id_type_c == RM_ALU) || (id_type_c == LOAD)) begin
         id_dst_c = id_rt_c;
      end
      wb_we_c = writes_reg(memwb_type_q) && in_rf(memwb_dst_q);
      id_a_c  = '0;
      id_b_c  = '0;
      if (in_rf(id_rs_c)) begin
         id_a_c = (wb_we_c && (memwb_dst_q == id_rs_c)) ? memwb_res_q : rf_q[RF_AW'(id_rs_c)];
      end
      if (in_rf(id_rt_c)) begin
         id_b_c = (wb_we_c && (memwb_dst_q == id_rt_c)) ? memwb_res_q : rf_q[RF_AW'(id_rt_c)];
      end
      hlt_in_id_c = (id_type_c == HALT);
   end

   core_fwd_unit u_fwd (
      .id_type_i    (id_type_c),
      .id_rs_i      (id_rs_c),
      .id_rt_i      (id_rt_c),
      .ex_type_i    (idex_type_q),
      .ex_rs_i      (idex_rs_q),
      .ex_rt_i      (idex_rt_q),
      .ex_dst_i     (idex_dst_q),
      .exmem_type_i (exmem_type_q),
      .exmem_dst_i  (exmem_dst_q),
      .memwb_type_i (memwb_type_q),
      .memwb_dst_i  (memwb_dst_q),
      .fwd_a_c_o    (fwd_a_c),
      .fwd_b_c_o    (fwd_b_c),
      .load_use_c_o (load_use_c)
   );

   assign stall_c = load_use_c && !halted_q;

   // EX operand muxing, ALU and branch resolution.
   always_comb begin
      case (fwd_a_c)
         FWD_EXMEM: ex_a_c = exmem_alu_q;
         FWD_MEMWB: ex_a_c = memwb_res_q;
         default:   ex_a_c = idex_a_q;
      endcase
      case (fwd_b_c)
         FWD_EXMEM: ex_rt_c = exmem_alu_q;
         FWD_MEMWB: ex_rt_c = memwb_res_q;
         default:   ex_rt_c = idex_b_q;
      endcase
      ex_b_c = (idex_type_q == RR_ALU) ? ex_rt_c : idex_imm_q;
      case (idex_op_q)
         OP_SUB, OP_SUBI: ex_alu_c = ex_a_c - ex_b_c;
         OP_AND:          ex_alu_c = ex_a_c & ex_b_c;
         OP_OR:           ex_alu_c = ex_a_c | ex_b_c;
         OP_CMP, OP_CMPI: ex_alu_c = XLEN'(ex_a_c < ex_b_c);
         OP_MUL:          ex_alu_c = ex_a_c * ex_b_c;
         default:         ex_alu_c = ex_a_c + ex_b_c;
      endcase
      br_taken_c = (idex_type_q == BRANCH) &&
                   ((idex_op_q == OP_BEQZ) ? (ex_a_c == '0) : (ex_a_c != '0));
      br_tgt_c   = idex_npc_q + AW'(idex_imm_q);
   end

   // Fetch control: branch redirect beats the halt freeze, which beats the load-use hold.
   always_comb begin
      pc_d       = pc_q + AW'(1);
      ifid_vld_d = 1'b1;
      ifid_ld_c  = 1'b1;
      stop_d     = stop_q;
      if (br_taken_c) begin
         pc_d       = br_tgt_c;
         ifid_vld_d = 1'b0;
         ifid_ld_c  = 1'b0;
      end else if (stop_q || hlt_in_id_c) begin
         pc_d       = pc_q;
         ifid_vld_d = 1'b0;
         ifid_ld_c  = 1'b0;
         stop_d     = 1'b1;
      end else if (stall_c) begin
         pc_d       = pc_q;
         ifid_vld_d = ifid_vld_q;
         ifid_ld_c  = 1'b0;
      end
   end

   // PC and IF/ID register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= '0;
         stop_q     <= 1'b0;
         ifid_vld_q <= 1'b0;
         ifid_ir_q  <= '0;
         ifid_npc_q <= '0;
      end else begin
         pc_q       <= pc_d;
         stop_q     <= stop_d;
         ifid_vld_q <= ifid_vld_d;
         if (ifid_ld_c) begin
            ifid_ir_q  <= imem_rdata;
            ifid_npc_q <= pc_q + AW'(1);
         end
      end
   end

   // ID/EX register; a bubble is injected on flush or load-use stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idex_type_q <= NONE;
         idex_op_q   <= '0;
         idex_rs_q   <= '0;
         idex_rt_q   <= '0;
         idex_dst_q  <= '0;
         idex_a_q    <= '0;
         idex_b_q    <= '0;
         idex_imm_q  <= '0;
         idex_npc_q  <= '0;
      end else begin
         idex_type_q <= (br_taken_c || stall_c) ? NONE : id_type_c;
         idex_op_q   <= id_op_c;
         idex_rs_q   <= id_rs_c;
         idex_rt_q   <= id_rt_c;
         idex_dst_q  <= id_dst_c;
         idex_a_q    <= id_a_c;
         idex_b_q    <= id_b_c;
         idex_imm_q  <= id_imm_c;
         idex_npc_q  <= ifid_npc_q;
      end
   end

   // EX/MEM and MEM/WB registers plus the sticky halt flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exmem_type_q <= NONE;
         exmem_dst_q  <= '0;
         exmem_alu_q  <= '0;
         exmem_sd_q   <= '0;
         memwb_type_q <= NONE;
         memwb_dst_q  <= '0;
         memwb_res_q  <= '0;
         halted_q     <= 1'b0;
      end else begin
         exmem_type_q <= idex_type_q;
         exmem_dst_q  <= idex_dst_q;
         exmem_alu_q  <= ex_alu_c;
         exmem_sd_q   <= ex_rt_c;
         memwb_type_q <= exmem_type_q;
         memwb_dst_q  <= exmem_dst_q;
         memwb_res_q  <= (exmem_type_q == LOAD) ? dmem_rdata : exmem_alu_q;
         if (memwb_type_q == HALT) begin
            halted_q <= 1'b1;
         end
      end
   end

   // Register file write on the WB edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) begin
            rf_q[i] <= '0;
         end
      end else if (wb_we_c) begin
         rf_q[RF_AW'(memwb_dst_q)] <= memwb_res_q;
      end
   end

   assign imem_addr  = pc_q;
   assign dmem_addr  = AW'(exmem_alu_q);
   assign dmem_wdata = exmem_sd_q;
   assign dmem_we    = (exmem_type_q == STORE);
   assign retire     = (memwb_type_q != NONE);
   assign halted     = halted_q;
   assign dbg_rdata  = in_rf(dbg_raddr) ? rf_q[RF_AW'(dbg_raddr)] : '0;

endmodule

// File: tb/tb_pipelined_core_fwd.sv
// Directed-program bench for pipelined_core_fwd with bench-side instruction/data memories.
module tb_pipelined_core_fwd;
   import core_pkg::*;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 10;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [AW-1:0]   imem_addr;
   logic [31:0]     imem_rdata;
   logic [AW-1:0]   dmem_addr;
   logic [XLEN-1:0] dmem_rdata;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_we;
   logic            retire;
   logic            halted;
   logic [4:0]      dbg_raddr = 5'd0;
   logic [XLEN-1:0] dbg_rdata;

   logic [31:0]     imem [1024];
   logic [31:0]     dmem [1024];
   logic            tb_wr = 1'b0;
   logic [AW-1:0]   tb_wa = '0;
   logic [31:0]     tb_wd = '0;

   int n_chk = 0;
   int n_fail = 0;
   int cyc, halt_cyc, we_cyc, we_first;
   bit ret_log [64];

   pipelined_core_fwd #(.XLEN(XLEN), .AW(AW), .NREG(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .dmem_addr  (dmem_addr),
      .dmem_rdata (dmem_rdata),
      .dmem_wdata (dmem_wdata),
      .dmem_we    (dmem_we),
      .retire     (retire),
      .halted     (halted),
      .dbg_raddr  (dbg_raddr),
      .dbg_rdata  (dbg_rdata)
   );

   always #5 clk = ~clk;

   assign imem_rdata = imem[imem_addr];
   assign dmem_rdata = dmem[dmem_addr];

   always @(posedge clk) begin
      if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
      else if (tb_wr) dmem[tb_wa] <= tb_wd;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rr(input opcode_t op, input int rd, input int rs, input int rt);
      return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction

   function automatic logic [31:0] ri(input opcode_t op, input int rt, input int rs, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] ret_bits(input int lo, input int hi);
      logic [31:0] v = '0;
      for (int i = lo; i <= hi; i++) v = {v[30:0], ret_log[i]};
      return v;
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 1024; i++) imem[i] = {OP_HLT, 26'd0};
   endtask

   task automatic poke(input int a, input logic [31:0] d);
      tb_wr = 1'b1; tb_wa = AW'(a); tb_wd = d;
      @(posedge clk); #1;
      tb_wr = 1'b0;
   endtask

   task automatic start_reset();
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst = 1'b0;
      cyc = 0; halt_cyc = -1; we_cyc = 0; we_first = -1;
      for (int i = 0; i < 64; i++) ret_log[i] = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc < 64) ret_log[cyc] = retire;
      if (dmem_we) begin
         we_cyc++;
         if (we_first < 0) we_first = cyc;
      end
      if (halted && halt_cyc < 0) halt_cyc = cyc;
   endtask

   task automatic run_prog(input int limit);
      while (halt_cyc < 0 && cyc < limit) step();
      if (halt_cyc < 0) chk("halt_timeout", 32'(halted), 32'd1);
      repeat (2) step();
   endtask

   task automatic chk_reg(input string tag, input int r, input logic [31:0] exp);
      dbg_raddr = 5'(r);
      #1;
      chk(tag, dbg_rdata, exp);
   endtask

   task automatic load_mul_prog();
      clear_imem();
      imem[0] = ri(OP_ADDI, 1, 0, -1);
      imem[1] = rr(OP_MUL, 2, 1, 1);
      imem[2] = ri(OP_SW, 2, 0, 0);
      imem[3] = ri(OP_CMPI, 3, 1, 1);
   endtask

   initial begin
      clear_imem();
      for (int i = 0; i < 1024; i++) dmem[i] = 32'd0;

      // Reset state
      @(negedge clk); @(negedge clk);
      chk("rst_pc", 32'(imem_addr), 32'd0);
      chk("rst_retire", 32'(retire), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_we", 32'(dmem_we), 32'd0);
      chk_reg("rst_r1", 1, 32'd0);

      // Dependent ADDIs forwarded back-to-back
      start_reset();
      clear_imem();
      imem[0] = ri(OP_ADDI, 1, 0, 5);
      imem[1] = ri(OP_ADDI, 2, 1, 3);
      release_rst();
      run_prog(40);
      chk_reg("t1_r1", 1, 32'd5);
      chk_reg("t1_r2", 2, 32'd8);
      chk("t1_retire_pattern", ret_bits(3, 7), 32'h0E);
      chk("t1_halt_cycle", 32'(halt_cyc), 32'd7);
      chk("t1_idle_retire", 32'(retire), 32'd0);
      chk("t1_pc_frozen", 32'(imem_addr), 32'd3);

      // Load-use: one bubble
      start_reset();
      poke(4, 32'd7);
      clear_imem();
      imem[0] = ri(OP_LW, 3, 0, 4);
      imem[1] = rr(OP_ADD, 4, 3, 3);
      release_rst();
      run_prog(40);
      chk_reg("t2_r3", 3, 32'd7);
      chk_reg("t2_r4", 4, 32'd14);
      chk("t2_retire_pattern", ret_bits(3, 8), 32'h16);
      chk("t2_halt_cycle", 32'(halt_cyc), 32'd8);

      // Taken BEQZ: two-cycle penalty
      start_reset();
      clear_imem();
      imem[0] = ri(OP_BEQZ, 0, 0, 2);
      imem[1] = ri(OP_ADDI, 5, 0, 1);
      imem[2] = ri(OP_ADDI, 5, 0, 2);
      imem[3] = ri(OP_ADDI, 6, 0, 9);
      release_rst();
      run_prog(40);
      chk_reg("t3_r5", 5, 32'd0);
      chk_reg("t3_r6", 6, 32'd9);
      chk("t3_retire_pattern", ret_bits(3, 9), 32'h26);
      chk("t3_halt_cycle", 32'(halt_cyc), 32'd9);

      // Not-taken BNEZ R0 falls through
      start_reset();
      imem[0] = ri(OP_BNEZ, 0, 0, 2);
      release_rst();
      run_prog(40);
      chk_reg("t3b_r5", 5, 32'd2);
      chk_reg("t3b_r6", 6, 32'd9);
      chk("t3b_retire_pattern", ret_bits(3, 9), 32'h3E);

      // MUL wraps, SW data forwarded, unsigned CMPI
      start_reset();
      poke(0, 32'hDEAD_BEEF);
      load_mul_prog();
      release_rst();
      run_prog(40);
      chk_reg("t4_r1", 1, 32'hFFFF_FFFF);
      chk_reg("t4_r2", 2, 32'd1);
      chk_reg("t4_r3", 3, 32'd0);
      chk("t4_dmem0", dmem[0], 32'd1);
      chk("t4_we_cycles", 32'(we_cyc), 32'd1);
      chk("t4_we_first", 32'(we_first), 32'd5);
      chk("t4_halt_cycle", 32'(halt_cyc), 32'd9);

      // Branch over HLT, write to R0 ignored
      start_reset();
      clear_imem();
      imem[0] = ri(OP_ADDI, 1, 0, 3);
      imem[1] = ri(OP_BNEZ, 0, 1, 1);
      imem[2] = {OP_HLT, 26'd0};
      imem[3] = rr(OP_ADD, 0, 1, 1);
      imem[4] = rr(OP_ADD, 7, 0, 1);
      release_rst();
      run_prog(40);
      chk_reg("t5_r0", 0, 32'd0);
      chk_reg("t5_r7", 7, 32'd3);
      chk("t5_retire_pattern", ret_bits(3, 11), 32'hCE);
      chk("t5_halt_cycle", 32'(halt_cyc), 32'd11);

      // Reset while SW is in MEM, then rerun
      start_reset();
      poke(0, 32'hDEAD_BEEF);
      load_mul_prog();
      release_rst();
      repeat (5) step();
      chk("t6_we_before", 32'(dmem_we), 32'd1);
      chk_reg("t6_r1_before", 1, 32'hFFFF_FFFF);
      #1 rst = 1'b1;
      #1;
      chk("t6_we_async_drop", 32'(dmem_we), 32'd0);
      @(negedge clk);
      chk("t6_rst_pc", 32'(imem_addr), 32'd0);
      chk_reg("t6_rst_r1", 1, 32'd0);
      chk_reg("t6_rst_r2", 2, 32'd0);
      chk("t6_store_aborted", dmem[0], 32'hDEAD_BEEF);
      release_rst();
      run_prog(40);
      chk_reg("t6_r1", 1, 32'hFFFF_FFFF);
      chk_reg("t6_r2", 2, 32'd1);
      chk_reg("t6_r3", 3, 32'd0);
      chk("t6_dmem0", dmem[0], 32'd1);
      chk("t6_halt_cycle", 32'(halt_cyc), 32'd9);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
